stream_mux: RTL and testbench



---
 rtl/stream_mux_if.sv | 27 ++
 rtl/stream_mux.sv | 110 +++++++++++
 tb/tb_stream_mux.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_if.sv
// Handshake and data bundle for stream_mux: per-channel input streams, one registered output stream.
interface stream_mux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/stream_mux.sv
// Registered N:1 stream multiplexer: fixed select, or round-robin when STREAM_MUX_RR_EN is defined.
// Without STREAM_MUX_RR_EN the mode input is ignored and the block always uses fixed select.
module stream_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int EXT   = 1 << SEL_W;

  logic [EXT-1:0]   valid_ext;
  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  int unsigned      idx;
`else
  logic             unused_mode;
  assign unused_mode = bus.mode;
`endif

  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    valid_ext                 = '0;
    valid_ext[CHANNELS-1:0]   = bus.in_valid;
    grant_vld                 = 1'b0;
    grant                     = '0;
`ifdef STREAM_MUX_RR_EN
    idx = 0;
    if (bus.mode) begin
      // Search ptr, ptr+1, ... wrapping at CHANNELS rather than 2^SEL_W.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_vld && valid_ext[idx[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant     = idx[SEL_W-1:0];
        end
      end
    end else
`endif
    if (int'(bus.sel) < CHANNELS && valid_ext[bus.sel]) begin
      grant_vld = 1'b1;
      grant     = bus.sel;
    end
  end

  assign grant_data = bus.in_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      bus.in_ready[c] = rst_n && load && grant_vld && (32'(grant) == c);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_chan_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

`ifdef STREAM_MUX_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (bus.mode && load && grant_vld) begin
      ptr_d = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios plus randomized traffic against a reference model.
module tb_stream_mux;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(16), .CHANNELS(16)) a ();
  stream_mux_if #(.WIDTH(16), .CHANNELS(12)) b ();

  stream_mux #(.WIDTH(16), .CHANNELS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  stream_mux #(.WIDTH(16), .CHANNELS(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  // Reference state for dut_a
  bit          m_valid;
  logic [15:0] m_data;
  int          m_chan;
  int          m_ptr;

  function automatic int ref_grant(input logic [15:0] v, input int s, input bit md,
                                   input int ptr, input int ch);
    if (RR && md) begin
      for (int k = 0; k < ch; k++) begin
        int c;
        c = (ptr + k) % ch;
        if (v[c]) return c;
      end
      return -1;
    end
    if (s < ch && v[s]) return s;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
  endtask

  // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
  task automatic cyc_a(input string tag);
    int g; bit ld; logic [15:0] exp_rdy;
    #3;
    ld = !m_valid || a.out_ready;
    g = ref_grant(a.in_valid, int'(a.sel), a.mode, m_ptr, 16);
    exp_rdy = (ld && g >= 0) ? (16'h1 << g) : 16'h0;
    total++;
    if (a.in_ready !== exp_rdy) begin
      bad++; $display("FAIL %s in_ready got=%h want=%h", tag, a.in_ready, exp_rdy);
    end
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = a.in_data[g*16 +: 16]; m_chan = g;
        if (RR && a.mode) m_ptr = (g + 1) % 16;
      end else m_valid = 0;
    end
    #1;
    total++;
    if (a.out_valid !== m_valid) begin
      bad++; $display("FAIL %s out_valid got=%b want=%b", tag, a.out_valid, m_valid);
    end
    if (m_valid) begin
      total++;
      if (a.out_data !== m_data || int'(a.out_chan) != m_chan) begin
        bad++; $display("FAIL %s out got=%h/%0d want=%h/%0d", tag, a.out_data, a.out_chan, m_data, m_chan);
      end
    end
  endtask

  task automatic test_reset();
    a.mode = 0; a.sel = 4'd3; a.in_valid = '1; a.in_data = '0; a.out_ready = 1;
    b.mode = 0; b.sel = 4'd0; b.in_valid = '0; b.in_data = '0; b.out_ready = 1;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (a.out_valid !== 1'b0 || a.out_data !== 16'h0 || a.out_chan !== 4'h0 || a.in_ready !== 16'h0) begin
      bad++; $display("FAIL reset got=%b/%h/%h/%h want=0/0/0/0", a.out_valid, a.out_data, a.out_chan, a.in_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_fixed();
    a.mode = 0; a.sel = 4'd3; a.in_valid = 16'h0008; a.out_ready = 1;
    a.in_data = '0; a.in_data[3*16 +: 16] = 16'hBEEF;
    cyc_a("fixed");
    total++;
    if (a.out_valid !== 1'b1 || a.out_data !== 16'hBEEF || a.out_chan !== 4'd3) begin
      bad++; $display("FAIL fixed_word got=%b/%h/%0d want=1/beef/3", a.out_valid, a.out_data, a.out_chan);
    end
  endtask

  task automatic test_backpressure();
    a.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a.in_data[3*16 +: 16] = 16'h1000 + 16'(i);
      cyc_a("bp_hold");
    end
    total++;
    if (a.out_data !== 16'hBEEF) begin
      bad++; $display("FAIL bp_held got=%h want=beef", a.out_data);
    end
    a.out_ready = 1; a.in_data[3*16 +: 16] = 16'hCAFE;
    cyc_a("bp_release");
    total++;
    if (a.out_data !== 16'hCAFE) begin
      bad++; $display("FAIL bp_new got=%h want=cafe", a.out_data);
    end
  endtask

`ifdef STREAM_MUX_RR_EN
  task automatic test_rr_fair();
    a.mode = 1; a.in_valid = '1; a.out_ready = 1;
    for (int i = 0; i < 18; i++) begin
      cyc_a("rr_all");
      total++;
      if (int'(a.out_chan) != i % 16) begin
        bad++; $display("FAIL rr_seq got=%0d want=%0d", a.out_chan, i % 16);
      end
    end
    a.in_valid = 16'h0204;
    for (int i = 0; i < 4; i++) begin
      cyc_a("rr_pair");
      total++;
      if (int'(a.out_chan) != ((i % 2 == 0) ? 2 : 9)) begin
        bad++; $display("FAIL rr_pair got=%0d want=%0d", a.out_chan, (i % 2 == 0) ? 2 : 9);
      end
    end
  endtask
`else
  task automatic test_macro_off();
    a.mode = 1; a.sel = 4'd5; a.in_valid = '1; a.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc_a("off");
      total++;
      if (a.out_chan !== 4'd5 || a.out_valid !== 1'b1) begin
        bad++; $display("FAIL off_chan got=%0d/%b want=5/1", a.out_chan, a.out_valid);
      end
    end
  endtask
`endif

  task automatic test_out_of_range();
    b.mode = 0; b.sel = 4'd13; b.in_valid = '1; b.out_ready = 1;
    for (int c = 0; c < 12; c++) b.in_data[c*16 +: 16] = 16'hA000 + 16'(c);
    for (int i = 0; i < 3; i++) begin
      #3;
      total++;
      if (b.in_ready !== 12'h0) begin
        bad++; $display("FAIL oor_ready got=%h want=000", b.in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (b.out_valid !== 1'b0) begin
        bad++; $display("FAIL oor_valid got=%b want=0", b.out_valid);
      end
    end
    b.sel = 4'd11;
    #3;
    total++;
    if (b.in_ready !== 12'h800) begin
      bad++; $display("FAIL sel11_ready got=%h want=800", b.in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (b.out_valid !== 1'b1 || b.out_chan !== 4'd11 || b.out_data !== 16'hA00B) begin
      bad++; $display("FAIL sel11_out got=%b/%0d/%h want=1/11/a00b", b.out_valid, b.out_chan, b.out_data);
    end
    b.in_valid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a.mode      = 1'($urandom);
      a.sel       = 4'($urandom);
      a.in_valid  = 16'($urandom) & 16'($urandom);
      a.out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 16; c++) a.in_data[c*16 +: 16] = 16'($urandom);
      cyc_a("random");
    end
  endtask

  task automatic test_reset_mid();
    // Park the pointer at 7 by serving ch6 in round-robin mode.
    a.mode = 1; a.sel = 4'd6; a.in_valid = 16'h0040; a.out_ready = 1;
    a.in_data[6*16 +: 16] = 16'h7777;
    cyc_a("pre_reset");
    a.out_ready = 0;
    rst_n = 0;
    #1;
    total++;
    if (a.out_valid !== 1'b0 || a.out_data !== 16'h0 || a.out_chan !== 4'h0 || a.in_ready !== 16'h0) begin
      bad++; $display("FAIL async_reset got=%b/%h/%h/%h want=0/0/0/0", a.out_valid, a.out_data, a.out_chan, a.in_ready);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    a.in_valid = '1; a.out_ready = 1; a.sel = 4'd5;
    cyc_a("post_reset");
    total++;
    if (int'(a.out_chan) != (RR ? 0 : 5)) begin
      bad++; $display("FAIL post_reset_chan got=%0d want=%0d", a.out_chan, RR ? 0 : 5);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
`ifdef STREAM_MUX_RR_EN
    test_rr_fair();
`else
    test_macro_off();
`endif
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
